uart_rx_cfg: RTL
================

UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL have parameter NB_DATA, default 8, data bits per frame, legal range 5..9.
REQ-002 SHALL have parameter OVERSAMPLE, default 16, i_s_tick pulses per bit, even, minimum 8.
REQ-003 SHALL have parameter PARITY_EN, default 1, 1 = a parity bit follows the data bits.
REQ-004 SHALL have parameter PARITY_ODD, default 0, 0 = even parity, 1 = odd parity.
REQ-005 SHALL have parameter STOP_BITS, default 1, stop bits per frame, legal values 1 or 2.
REQ-006 SHALL have port i_clk  input  1  system clock; all state updates on rising edge.
REQ-007 SHALL have port i_reset  input  1  reset, asynchronous, active-low (0 = reset).
REQ-008 SHALL have port i_s_tick  input  1  one-cycle oversample tick enable.
REQ-009 SHALL have port i_rx  input  1  asynchronous serial line, idle high.
REQ-010 SHALL have port i_ready  input  1  consumer accepts the held word.
REQ-011 SHALL have port o_data  output  NB_DATA  received word, LSB first on the line.
REQ-012 SHALL have port o_valid  output  1  o_data and the error flags are valid.
REQ-013 SHALL have port o_parity_err  output  1  parity mismatch on the held word.
REQ-014 SHALL have port o_frame_err  output  1  a stop bit was sampled low on the held word.
REQ-015 SHALL have port o_break  output  1  held word is a break: all data, parity and stop samples low.
REQ-016 SHALL have port o_overrun  output  1  sticky; a completed frame was dropped.

Function
REQ-017 SHALL pass i_rx through a 2-flop synchronizer (rx_s); all logic uses rx_s only.
REQ-018 SHALL implement states IDLE, START, DATA, PARITY, STOP; PARITY SHALL be skipped when PARITY_EN=0.
REQ-019 IDLE: SHALL enter START, with tick counter cleared, on a clock where rx_s=0 and the previous rx_s=1 (falling edge only).
REQ-020 The tick counter SHALL advance only on i_s_tick and SHALL hold otherwise.
REQ-021 START: on ticks with count = OVERSAMPLE/2-2, -1, 0 relative to OVERSAMPLE/2, SHALL sample rx_s. Decision at count OVERSAMPLE/2 by majority of 3: 0 -> DATA with count cleared; 1 -> IDLE (false start, no output).
REQ-022 DATA, PARITY, STOP: each bit SHALL span OVERSAMPLE ticks. Samples at counts OVERSAMPLE-3, -2, -1; bit value = majority of 3; decision on the count OVERSAMPLE-1 tick; count then wraps to 0.
REQ-023 DATA SHALL shift bits in LSB first and advance after NB_DATA bits.
REQ-024 Parity check: parity_err = (XOR of data bits XOR parity bit) != PARITY_ODD.
REQ-025 STOP: frame_err SHALL be set if any stop bit decides 0. After the last stop decision the FSM SHALL return to IDLE and complete the frame.
REQ-026 Break: SHALL be flagged when all data bits are 0, the parity bit (if present) is 0, and the first stop bit is 0. Frame_err SHALL also be set. No new start SHALL be detected until rx_s returns high (per REQ-019).
REQ-027 Completion SHALL occur on the cycle after the final stop decision. Load o_data and all flags, and set o_valid=1, if o_valid=0 or i_ready=1 on that cycle.
REQ-028 If o_valid=1 and i_ready=0 at completion: SHALL drop the new frame, keep the held word unchanged, and set o_overrun=1.
REQ-029 Handshake: o_valid SHALL clear on a cycle with o_valid & i_ready unless a load occurs on the same cycle. o_data and flags SHALL be stable while o_valid=1 & i_ready=0.
REQ-030 o_overrun SHALL clear on the next accepted handshake (o_valid & i_ready) and SHALL be set again if an overrun coincides with it.
REQ-031 Reception SHALL continue regardless of i_ready (no backpressure to the line).

Reset
REQ-032 i_reset=0 SHALL asynchronously force: FSM=IDLE, counters=0, synchronizer flops=1, o_data=0, o_valid=0, and all error flags and o_overrun=0.
REQ-033 Reset mid-frame SHALL discard the partial frame. After release, the next falling edge of rx_s SHALL start a new frame.

Verification (NB_DATA=8, OVERSAMPLE=16, PARITY_EN=1, PARITY_ODD=0, STOP_BITS=1)
REQ-034 Send 0x55 with parity 0 and stop 1, i_ready=1 -> o_valid pulse, o_data=0x55, all errors 0.
REQ-035 Send 0xA7 with parity bit 0 (wrong) -> o_data=0xA7, o_parity_err=1. Send 0x3C with stop bit 0 -> o_frame_err=1, o_break=0.
REQ-036 Low glitch of 4 ticks on idle line -> no o_valid. Single-tick low spike mid-bit of 0xFF -> o_data=0xFF (majority filter).
REQ-037 i_ready=0, send 0x11 then 0x22 -> o_data stays 0x11, o_overrun=1. Raise i_ready for one cycle -> o_valid=0, o_overrun=0.
REQ-038 Line low for 20 bit times -> one word 0x00 with o_break=1 and o_frame_err=1, then no further frames until the line goes high. Then send 0x5A -> o_data=0x5A.
REQ-039 Assert i_reset=0 during data bit 4 of a frame -> outputs 0 immediately. Release, then send 0xC3 -> o_data=0xC3, errors 0.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// Oversampled UART receiver: majority-of-3 bit decisions, optional parity, 1-2 stop bits, break detect.
// Output word is loaded the cycle after the last stop decision; a full holding register drops new frames and flags overrun.
module uart_rx_cfg #(
  parameter int NB_DATA    = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_s_tick,
  input  logic               i_rx,
  input  logic               i_ready,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_valid,
  output logic               o_parity_err,
  output logic               o_frame_err,
  output logic               o_break,
  output logic               o_overrun
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(NB_DATA);
  localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
  localparam logic ODD = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t state, state_nxt;
  logic rx_meta, rx_s, rx_d;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0] smp, smp_nxt;
  logic [BW-1:0] bit_cnt, bit_cnt_nxt;
  logic stop_cnt, stop_cnt_nxt;
  logic [NB_DATA-1:0] shreg, shreg_nxt;
  logic par_acc, par_nxt, pbit, pbit_nxt;
  logic zero_acc, zero_nxt, ferr_acc, ferr_nxt, brk_acc, brk_nxt;
  logic done, done_nxt;
  logic sample_pt, decide, bit_val, perr_calc;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  // START samples around the half-bit point; every later bit samples at the end of its window.
  assign sample_pt = i_s_tick && (state != IDLE) &&
                     ((state == START) ? (cnt >= HALF - CW'(2) && cnt <= HALF) : (cnt >= LAST - CW'(2)));
  assign decide    = i_s_tick && (cnt == ((state == START) ? HALF : LAST));
  assign bit_val   = maj3(smp[1], smp[0], rx_s);
  assign perr_calc = (PARITY_EN != 0) && ((par_acc ^ pbit) != ODD);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state    <= IDLE;
      cnt      <= '0;
      smp      <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      shreg    <= '0;
      par_acc  <= 1'b0;
      pbit     <= 1'b0;
      zero_acc <= 1'b0;
      ferr_acc <= 1'b0;
      brk_acc  <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      smp      <= smp_nxt;
      bit_cnt  <= bit_cnt_nxt;
      stop_cnt <= stop_cnt_nxt;
      shreg    <= shreg_nxt;
      par_acc  <= par_nxt;
      pbit     <= pbit_nxt;
      zero_acc <= zero_nxt;
      ferr_acc <= ferr_nxt;
      brk_acc  <= brk_nxt;
      done     <= done_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    smp_nxt      = smp;
    bit_cnt_nxt  = bit_cnt;
    stop_cnt_nxt = stop_cnt;
    shreg_nxt    = shreg;
    par_nxt      = par_acc;
    pbit_nxt     = pbit;
    zero_nxt     = zero_acc;
    ferr_nxt     = ferr_acc;
    brk_nxt      = brk_acc;
    done_nxt     = 1'b0;
    if (sample_pt) smp_nxt = {smp[0], rx_s};
    if (i_s_tick && state != IDLE) cnt_nxt = cnt + 1'b1;
    case (state)
      IDLE: begin
        if (!rx_s && rx_d) begin
          state_nxt = START;
          cnt_nxt   = '0;
        end
      end
      START: begin
        if (decide) begin
          cnt_nxt = '0;
          if (!bit_val) begin
            state_nxt    = DATA;
            bit_cnt_nxt  = '0;
            stop_cnt_nxt = 1'b0;
            par_nxt      = 1'b0;
            pbit_nxt     = 1'b0;
            zero_nxt     = 1'b1;
            ferr_nxt     = 1'b0;
            brk_nxt      = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      DATA: begin
        if (decide) begin
          cnt_nxt   = '0;
          shreg_nxt = {bit_val, shreg[NB_DATA-1:1]};
          par_nxt   = par_acc ^ bit_val;
          zero_nxt  = zero_acc & ~bit_val;
          if (bit_cnt == BW'(NB_DATA - 1)) state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
          else bit_cnt_nxt = bit_cnt + 1'b1;
        end
      end
      PARITY: begin
        if (decide) begin
          cnt_nxt   = '0;
          pbit_nxt  = bit_val;
          zero_nxt  = zero_acc & ~bit_val;
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (decide) begin
          cnt_nxt = '0;
          if (!bit_val) ferr_nxt = 1'b1;
          if (!stop_cnt) brk_nxt = zero_acc & ~bit_val;
          if (stop_cnt == 1'(STOP_BITS - 1)) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            stop_cnt_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_break      <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      if (done && (!o_valid || i_ready)) begin
        o_data       <= shreg;
        o_parity_err <= perr_calc;
        o_frame_err  <= ferr_acc;
        o_break      <= brk_acc;
        o_valid      <= 1'b1;
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
      if (o_valid && i_ready) o_overrun <= 1'b0;
      if (done && o_valid && !i_ready) o_overrun <= 1'b1;
    end
  end

endmodule
